lane_permute_engine: RTL and testbench
======================================

# lane_permute_engine

Multi-round, handshaked permutation engine for a 5x5 lane state. It is the parametrised successor to the single-shot 25-bit swap stage in the matrix encoder datapath, generalised from 1-bit cells to LANE_W-bit lanes. It adds an inverse mode, lane rotation and a programmable round count. It sits between the line reader and the line writer, taking one state per transaction and returning the permuted state.

## Interface
- LANE_W, default 1: bits per lane. The state width is S = 25*LANE_W.
- RW, default 6: width of the round-count field.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input state offered
- in_ready  out  1  engine can accept; equals (state==IDLE) && !rst
- in_data  in  S  input state; lane i = bits [i*LANE_W +: LANE_W]; i = 5*y + x
- mode  in  2  round function, sampled with in_data: 00 pi, 01 pi-inverse, 10 rotate, 11 pi-then-rotate
- num_rounds  in  RW  rounds to apply, sampled with in_data; 0 = pass-through
- out_valid  out  1  result held on out_data
- out_ready  in  1  consumer accepts the result
- out_data  out  S  result state (the internal state register)
- busy  out  1  high in RUN or DONE

## Operation
- Position mapping p(i) for lane i = 5y+x:
  - x0=(x+3)%5, y0=(y+3)%5
  - nx=(y0+2)%5, ny=((2*x0+3*y0)%5+2)%5
  - p(i)=5*ny+nx
- Round functions:
  - pi: out[p(i)] = in[i].
  - pi-inverse: out[i] = in[p(i)].
  - rotate: lane j is rotated left by (j % LANE_W); this is a no-op when LANE_W=1.
  - pi-then-rotate: pi, then rotate with amounts indexed by destination lane.
- p is fixed combinational wiring. Lane 12 is a fixed point. Pi has order 24.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid, load state_reg<=in_data, mode_reg<=mode and cnt<=num_rounds. Go to RUN if num_rounds!=0, else go to DONE.
  - RUN: each cycle, state_reg<=f(mode_reg, state_reg) and cnt<=cnt-1. Go to DONE on the edge where cnt==1.
  - DONE: out_valid=1 and state_reg is frozen. When out_ready=1, go to IDLE.
- in_valid outside IDLE is ignored. No data is captured and there is no error. The upstream must hold its data until it sees in_ready.
- cnt is RW bits wide. num_rounds = 2^RW-1 runs the full count with no wrap.
- mode and num_rounds changing while busy have no effect.
- Simultaneous DONE handshake and in_valid: the FSM returns to IDLE first. The new input is accepted no earlier than the following cycle, so there is no same-cycle turnaround.

## Timing
- Reset values, asynchronous and immediate: state=IDLE, state_reg=0, cnt=0, mode_reg=0, out_valid=0, out_data=0, busy=0, in_ready=0 while rst is high.
- in_ready=1 on the first cycle after rst deasserts.
- Assertion of rst mid-RUN or mid-DONE aborts the transaction. Partial results are discarded and out_valid drops immediately.
- Latency is counted from the accept edge k, where in_valid && in_ready.
- out_valid rises after edge k+N for N>=1, or after edge k for N=0.
- out_valid stays high, with out_data stable, until the out_ready edge. It falls after that edge.
- Throughput is one transaction per N+2 cycles at best: accept, N rounds, DONE, plus the return to IDLE.
- in_ready, out_valid and busy are registered-state decodes. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Pi, LANE_W=1. in_data=25'h1, mode=00, N=1 gives out_data=1<<10 with out_valid 1 cycle after accept. in_data=1<<1 gives 1<<20. in_data=1<<12 gives 1<<12.
- Inverse round-trip. in_data=1<<10, mode=01, N=1 gives 25'h1. A random vector run 3 times forward and then 3 times inverse returns the original vector.
- Order. A random in_data with mode=00, N=24 returns out_data==in_data, with out_valid exactly 24 cycles after accept. N=0 returns in_data after 1 cycle.
- Rotate, LANE_W=4. Lane1=4'b0001 and lane5=4'b1000 with mode=10, N=1 give lane1=4'b0010 and lane5=4'b0001. Lane0 and lane4 are unchanged. Mode 11 matches a reference model of pi then rotate.
- Backpressure. Hold out_ready=0 for 10 cycles in DONE. out_data stays stable and in_ready stays 0. A second in_valid during this time is ignored. After out_ready=1, in_ready returns the next cycle.
- Reset mid-run. Start N=20, assert rst at round 7 asynchronously between edges. All outputs go to 0 immediately, and after release the next transaction completes correctly.

Source files
------------

// File: rtl/lane_permute_engine.sv
// lane_permute_engine
// Multi-round permutation of a 5x5 lane state. One state is accepted per
// transaction, num_rounds round functions are applied one per cycle, and the
// result is held until the consumer takes it.
module lane_permute_engine #(
  parameter int LANE_W = 1,
  parameter int RW     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [25*LANE_W-1:0]  in_data,
  input  logic [1:0]            mode,
  input  logic [RW-1:0]         num_rounds,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [25*LANE_W-1:0]  out_data,
  output logic                  busy
);

  localparam int S = 25 * LANE_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_t;

  fsm_t            fsm_reg;
  fsm_t            fsm_next;
  logic [S-1:0]    state_reg;
  logic [1:0]      mode_reg;
  logic [RW-1:0]   cnt_reg;
  logic [S-1:0]    round_next;

  logic [LANE_W-1:0] cur_lane   [25];
  logic [LANE_W-1:0] pi_lane    [25];
  logic [LANE_W-1:0] pinv_lane  [25];
  logic [LANE_W-1:0] rot_lane   [25];
  logic [LANE_W-1:0] pirot_lane [25];

  // Lane wiring: the position map and rotation amounts are elaboration-time
  // constants, so every round function is pure routing plus a final mux.
  for (genvar gi = 0; gi < 25; gi++) begin : g_lane
    localparam int X  = gi % 5;
    localparam int Y  = gi / 5;
    localparam int X0 = (X + 3) % 5;
    localparam int Y0 = (Y + 3) % 5;
    localparam int NX = (Y0 + 2) % 5;
    localparam int NY = ((2 * X0 + 3 * Y0) % 5 + 2) % 5;
    localparam int P  = 5 * NY + NX;
    localparam int R  = gi % LANE_W;

    assign cur_lane[gi]  = state_reg[gi*LANE_W +: LANE_W];
    assign pi_lane[P]    = cur_lane[gi];
    assign pinv_lane[gi] = cur_lane[P];

    // Rotation amount depends on the lane index only; amount 0 is a wire.
    if (R == 0) begin : g_norot
      assign rot_lane[gi]   = cur_lane[gi];
      assign pirot_lane[gi] = pi_lane[gi];
    end else begin : g_rot
      assign rot_lane[gi]   = {cur_lane[gi][LANE_W-1-R:0], cur_lane[gi][LANE_W-1:LANE_W-R]};
      assign pirot_lane[gi] = {pi_lane[gi][LANE_W-1-R:0],  pi_lane[gi][LANE_W-1:LANE_W-R]};
    end

    // Select the round function latched with the transaction.
    always_comb begin
      case (mode_reg)
        2'b00:   round_next[gi*LANE_W +: LANE_W] = pi_lane[gi];
        2'b01:   round_next[gi*LANE_W +: LANE_W] = pinv_lane[gi];
        2'b10:   round_next[gi*LANE_W +: LANE_W] = rot_lane[gi];
        default: round_next[gi*LANE_W +: LANE_W] = pirot_lane[gi];
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_reg <= IDLE;
    else     fsm_reg <= fsm_next;
  end

  // FSM next-state logic; a zero round count skips straight to DONE.
  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE:    if (in_valid) fsm_next = (num_rounds != '0) ? RUN : DONE;
      RUN:     if (cnt_reg == RW'(1)) fsm_next = DONE;
      DONE:    if (out_ready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // FSM outputs are pure state decodes; in_ready is also masked by reset.
  always_comb begin
    in_ready  = (fsm_reg == IDLE) && !rst;
    out_valid = (fsm_reg == DONE);
    busy      = (fsm_reg == RUN) || (fsm_reg == DONE);
  end

  // Datapath: capture on accept, one round per RUN cycle, frozen otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      mode_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg <= in_data;
            mode_reg  <= mode;
            cnt_reg   <= num_rounds;
          end
        end
        RUN: begin
          state_reg <= round_next;
          cnt_reg   <= cnt_reg - RW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = state_reg;

endmodule

// File: tb/tb_lane_permute_engine.sv
// Self-checking bench for lane_permute_engine (LANE_W=4): table of vectors
// plus hand-written backpressure, turnaround and reset-abort sequences.
module tb_lane_permute_engine;

  localparam int LW = 4;
  localparam int RW = 6;
  localparam int S  = 25 * LW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [S-1:0]  in_data = '0;
  logic [1:0]    mode = 2'b00;
  logic [RW-1:0] num_rounds = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [S-1:0]  out_data;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [S-1:0] exp_q[$];

  lane_permute_engine #(.LANE_W(LW), .RW(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mode       (mode),
    .num_rounds (num_rounds),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [S-1:0] got, input logic [S-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int p_of(int i);
    int x  = i % 5;
    int y  = i / 5;
    int x0 = (x + 3) % 5;
    int y0 = (y + 3) % 5;
    return 5 * (((2 * x0 + 3 * y0) % 5 + 2) % 5) + (y0 + 2) % 5;
  endfunction

  function automatic logic [S-1:0] pi_m(logic [S-1:0] s);
    logic [S-1:0] r = '0;
    for (int i = 0; i < 25; i++) r[p_of(i)*LW +: LW] = s[i*LW +: LW];
    return r;
  endfunction

  function automatic logic [S-1:0] pinv_m(logic [S-1:0] s);
    logic [S-1:0] r = '0;
    for (int i = 0; i < 25; i++) r[i*LW +: LW] = s[p_of(i)*LW +: LW];
    return r;
  endfunction

  function automatic logic [S-1:0] rot_m(logic [S-1:0] s);
    logic [S-1:0]  r = '0;
    logic [LW-1:0] v;
    logic [LW-1:0] t;
    int k;
    for (int j = 0; j < 25; j++) begin
      v = s[j*LW +: LW];
      k = j % LW;
      if (k == 0) t = v;
      else        t = (v << k) | (v >> (LW - k));
      r[j*LW +: LW] = t;
    end
    return r;
  endfunction

  function automatic logic [S-1:0] apply_m(logic [1:0] md, int n, logic [S-1:0] s);
    logic [S-1:0] r = s;
    for (int i = 0; i < n; i++) begin
      case (md)
        2'b00:   r = pi_m(r);
        2'b01:   r = pinv_m(r);
        2'b10:   r = rot_m(r);
        default: r = rot_m(pi_m(r));
      endcase
    end
    return r;
  endfunction

  function automatic logic [S-1:0] lane_vec(int i, logic [LW-1:0] v);
    logic [S-1:0] r = '0;
    r[i*LW +: LW] = v;
    return r;
  endfunction

  function automatic logic [S-1:0] rand_state();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[S-1:0];
  endfunction

  // One full transaction: offer, accept, wait for result, check, hand-shake.
  task automatic run_txn(input string name, input logic [S-1:0] din, input logic [1:0] md,
                         input int n, input logic [S-1:0] exp, output logic [S-1:0] got);
    int lat;
    logic [S-1:0] e;
    @(negedge clk);
    check({name, "/ready_before"}, in_ready, 1);
    in_valid = 1'b1; in_data = din; mode = md; num_rounds = RW'(n);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0; mode = ~md; num_rounds = RW'(7);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "/latency"}, lat, n);
    got = out_data;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : ~exp;
    check({name, "/data"}, got, e);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "/valid_after"}, out_valid, 0);
    check({name, "/ready_after"}, in_ready, 1);
    $display("txn %s mode=%0d n=%0d lat=%0d out=%h", name, md, n, lat, got);
  endtask

  typedef struct {
    logic [S-1:0] din;
    logic [1:0]   md;
    int           n;
    logic [S-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [S-1:0] r, got, got2, snap, d1, d2, d3;
    int lat;

    // Reset state while rst is held.
    #1;
    check("rst/in_ready", in_ready, 0);
    check("rst/out_valid", out_valid, 0);
    check("rst/busy", busy, 0);
    check("rst/out_data", out_data, '0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst/ready_release", in_ready, 1);

    // Vector table.
    vecs[0] = '{lane_vec(0, 4'h1), 2'b00, 1, lane_vec(10, 4'h1)};
    vecs[1] = '{lane_vec(1, 4'h1), 2'b00, 1, lane_vec(20, 4'h1)};
    vecs[2] = '{lane_vec(12, 4'h9), 2'b00, 1, lane_vec(12, 4'h9)};
    vecs[3] = '{lane_vec(10, 4'h1), 2'b01, 1, lane_vec(0, 4'h1)};
    r = rand_state();
    vecs[4] = '{r, 2'b00, 24, r};
    r = rand_state();
    vecs[5] = '{r, 2'b11, 0, r};
    vecs[6] = '{lane_vec(1, 4'b0001) | lane_vec(5, 4'b1000) | lane_vec(0, 4'b0011) | lane_vec(4, 4'b1010),
                2'b10, 1,
                lane_vec(1, 4'b0010) | lane_vec(5, 4'b0001) | lane_vec(0, 4'b0011) | lane_vec(4, 4'b1010)};
    r = rand_state();
    vecs[7] = '{r, 2'b11, 2, apply_m(2'b11, 2, r)};
    r = rand_state();
    vecs[8] = '{r, 2'b10, 3, apply_m(2'b10, 3, r)};
    r = rand_state();
    vecs[9] = '{r, 2'b01, 5, apply_m(2'b01, 5, r)};
    r = rand_state();
    vecs[10] = '{r, 2'b00, 63, apply_m(2'b00, 63, r)};

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("v%0d", i), vecs[i].din, vecs[i].md, vecs[i].n, vecs[i].exp, got);

    // Inverse round-trip: 3 forward then 3 inverse restores the input.
    r = rand_state();
    run_txn("fwd3", r, 2'b00, 3, apply_m(2'b00, 3, r), got);
    run_txn("inv3", got, 2'b01, 3, r, got2);

    // Backpressure, ignored in_valid while DONE, and no same-cycle turnaround.
    d1 = rand_state();
    d2 = rand_state();
    @(negedge clk);
    in_valid = 1'b1; in_data = d1; mode = 2'b00; num_rounds = RW'(3);
    exp_q.push_back(apply_m(2'b00, 3, d1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp/latency", lat, 3);
    snap = out_data;
    check("bp/data", snap, exp_q.pop_front());
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = d2; mode = 2'b00; num_rounds = RW'(1);
      @(posedge clk); #1;
      check($sformatf("bp/stable%0d", c), out_data, snap);
      check($sformatf("bp/ready%0d", c), in_ready, 0);
      check($sformatf("bp/valid%0d", c), out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("turn/valid_low", out_valid, 0);
    check("turn/ready_high", in_ready, 1);
    check("turn/not_busy", busy, 0);
    exp_q.push_back(pi_m(d2));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("turn/accepted", busy, 1);
    check("turn/ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("turn/valid", out_valid, 1);
    check("turn/data", out_data, exp_q.pop_front());
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("txn backpressure+turnaround done");

    // Reset abort mid-run.
    d3 = rand_state();
    @(negedge clk);
    in_valid = 1'b1; in_data = d3; mode = 2'b00; num_rounds = RW'(20);
    exp_q.push_back(apply_m(2'b00, 20, d3));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    check("abort/busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort/out_valid", out_valid, 0);
    check("abort/busy", busy, 0);
    check("abort/in_ready", in_ready, 0);
    check("abort/out_data", out_data, '0);
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("abort/ready_release", in_ready, 1);
    $display("txn reset-abort done");
    r = rand_state();
    run_txn("post_abort", r, 2'b11, 4, apply_m(2'b11, 4, r), got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
